// File: rtl/noc_pkg.sv
//==============================================================================
// Package : noc_pkg
// Shared NoC packet format and packet_send_arbiter state encoding.
// Rev 1.0 : initial release
//==============================================================================
`default_nettype none

package noc_pkg;

   localparam int PKT_W   = 35;

   localparam int DST_MSB = 34;
   localparam int DST_LSB = 31;
   localparam int SRC_MSB = 30;
   localparam int SRC_LSB = 27;
   localparam int TYP_MSB = 26;
   localparam int TYP_LSB = 25;
   localparam int PAY_MSB = 24;
   localparam int PAY_LSB = 0;

   typedef logic [PKT_W-1:0] pkt_t;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CAPTURE = 2'd1,
      SEND    = 2'd2,
      RETURN  = 2'd3
   } send_arb_state_t;

endpackage

`default_nettype wire

// File: rtl/packet_send_arbiter_rr_arbiter.sv
//==============================================================================
// Module : rr_arbiter
// Combinational rotating-priority picker: first request at or after i_ptr.
// Rev 1.0 : initial release
//==============================================================================
`default_nettype none

module rr_arbiter #(
   parameter  int N  = 4,
   localparam int IW = $clog2(N)
) (
   input  logic [N-1:0]  i_req,
   input  logic [IW-1:0] i_ptr,
   output logic [N-1:0]  o_gnt,
   output logic [IW-1:0] o_idx,
   output logic          o_any
);

   logic [IW-1:0] w_idx [N];
   logic [N-1:0]  w_rot;

   // w_rot[k] is the request sitting k places after the pointer
   for (genvar k = 0; k < N; k++) begin : g_rot
      assign w_idx[k] = IW'((int'(i_ptr) + k) % N);
      assign w_rot[k] = i_req[w_idx[k]];
   end

   always_comb begin
      o_any = 1'b0;
      o_idx = '0;
      for (int k = N-1; k >= 0; k--) begin
         if (w_rot[k]) begin
            o_any = 1'b1;
            o_idx = w_idx[k];
         end
      end
      o_gnt = o_any ? (N'(1) << o_idx) : '0;
   end

endmodule

`default_nettype wire

// File: rtl/packet_send_arbiter.sv
//==============================================================================
// Module : packet_send_arbiter
// Round-robin share of one 4-phase NoC injection port among N_PORTS packetizers.
// Rev 1.0 : initial release
//==============================================================================
`default_nettype none

module packet_send_arbiter
   import noc_pkg::*;
#(
   parameter  int N_PORTS = 4,
   parameter  int PKT_W   = noc_pkg::PKT_W,
   parameter  int CNT_W   = 16,
   localparam int IDX_W   = $clog2(N_PORTS)
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [N_PORTS-1:0]       in_req,
   output logic [N_PORTS-1:0]       in_ack,
   input  logic [N_PORTS*PKT_W-1:0] in_data,
   output logic                     out_req,
   input  logic                     out_ack,
   output logic [PKT_W-1:0]         out_data,
   output logic [IDX_W-1:0]         grant_idx,
   output logic                     busy,
   output logic [CNT_W-1:0]         pkt_count
);

   send_arb_state_t      r_state, w_state_nxt;
   logic [PKT_W-1:0]     r_buf, w_buf_nxt;
   logic [IDX_W-1:0]     r_rr_ptr, w_rr_ptr_nxt;
   logic [IDX_W-1:0]     r_grant, w_grant_nxt;
   logic [N_PORTS-1:0]   r_in_ack, w_in_ack_nxt;
   logic                 r_out_req, w_out_req_nxt;
   logic [PKT_W-1:0]     r_out_data, w_out_data_nxt;
   logic                 r_busy, w_busy_nxt;
   logic [CNT_W-1:0]     r_cnt, w_cnt_nxt;

   logic [N_PORTS-1:0]   w_arb_gnt;
   logic [IDX_W-1:0]     w_arb_idx;
   logic                 w_arb_any;
   logic [PKT_W-1:0]     w_sel_data;
   logic                 w_sel_req;

   rr_arbiter #(.N(N_PORTS)) u_rr_arbiter (
      .i_req (in_req),
      .i_ptr (r_rr_ptr),
      .o_gnt (w_arb_gnt),
      .o_idx (w_arb_idx),
      .o_any (w_arb_any)
   );

   assign w_sel_data = in_data[w_arb_idx*PKT_W +: PKT_W];
   assign w_sel_req  = in_req[r_grant];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= IDLE;
         r_buf      <= '0;
         r_rr_ptr   <= '0;
         r_grant    <= '0;
         r_in_ack   <= '0;
         r_out_req  <= 1'b0;
         r_out_data <= '0;
         r_busy     <= 1'b0;
         r_cnt      <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_buf      <= w_buf_nxt;
         r_rr_ptr   <= w_rr_ptr_nxt;
         r_grant    <= w_grant_nxt;
         r_in_ack   <= w_in_ack_nxt;
         r_out_req  <= w_out_req_nxt;
         r_out_data <= w_out_data_nxt;
         r_busy     <= w_busy_nxt;
         r_cnt      <= w_cnt_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (w_arb_any)  w_state_nxt = CAPTURE;
         CAPTURE: if (!w_sel_req) w_state_nxt = SEND;
         SEND:    if (out_ack)    w_state_nxt = RETURN;
         RETURN:  if (!out_ack)   w_state_nxt = IDLE;
         default:                 w_state_nxt = IDLE;
      endcase
   end

   // Next values for the registered outputs; everything holds unless its transition fires
   always_comb begin
      w_buf_nxt      = r_buf;
      w_rr_ptr_nxt   = r_rr_ptr;
      w_grant_nxt    = r_grant;
      w_in_ack_nxt   = r_in_ack;
      w_out_req_nxt  = r_out_req;
      w_out_data_nxt = r_out_data;
      w_cnt_nxt      = r_cnt;
      case (r_state)
         IDLE: begin
            if (w_arb_any) begin
               w_buf_nxt    = w_sel_data;
               w_grant_nxt  = w_arb_idx;
               w_in_ack_nxt = w_arb_gnt;
            end
         end
         CAPTURE: begin
            if (!w_sel_req) begin
               w_in_ack_nxt   = '0;
               w_out_req_nxt  = 1'b1;
               w_out_data_nxt = r_buf;
            end
         end
         SEND: begin
            if (out_ack) w_out_req_nxt = 1'b0;
         end
         RETURN: begin
            if (!out_ack) begin
               w_cnt_nxt    = r_cnt + CNT_W'(1);
               w_rr_ptr_nxt = (r_grant == IDX_W'(N_PORTS-1)) ? '0 : r_grant + IDX_W'(1);
            end
         end
         default: ;
      endcase
      w_busy_nxt = (w_state_nxt != IDLE);
   end

   assign in_ack    = r_in_ack;
   assign out_req   = r_out_req;
   assign out_data  = r_out_data;
   assign grant_idx = r_grant;
   assign busy      = r_busy;
   assign pkt_count = r_cnt;

endmodule

`default_nettype wire

// File: tb/tb_packet_send_arbiter.sv
//==============================================================================
// Module : tb_packet_send_arbiter
// Directed and randomized bench for packet_send_arbiter with 4-phase partner agents.
// Rev 1.0 : initial release
//==============================================================================
`default_nettype none

module tb_packet_send_arbiter;
   import noc_pkg::*;

   localparam int N  = 4;
   localparam int CW = 4;
   localparam int IW = 2;

   logic               clk = 1'b0;
   logic               rst_n;
   logic [N-1:0]       in_req;
   logic [N-1:0]       in_ack;
   logic [N*PKT_W-1:0] in_data;
   logic               out_req;
   logic               out_ack;
   logic [PKT_W-1:0]   out_data;
   logic [IW-1:0]      grant_idx;
   logic               busy;
   logic [CW-1:0]      pkt_count;

   always #5 clk = ~clk;

   packet_send_arbiter #(.N_PORTS(N), .PKT_W(PKT_W), .CNT_W(CW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_req    (in_req),
      .in_ack    (in_ack),
      .in_data   (in_data),
      .out_req   (out_req),
      .out_ack   (out_ack),
      .out_data  (out_data),
      .grant_idx (grant_idx),
      .busy      (busy),
      .pkt_count (pkt_count)
   );

   int            n_checks = 0;
   int            n_pass   = 0;
   pkt_t          src_q [N][$];
   int            src_wait [N];
   int            src_wait_max = 0;
   pkt_t          exp_q [$];
   int            got_order [$];
   int            noc_delay = 0;
   bit            noc_rand  = 1'b0;
   int            noc_cnt   = 0;
   int            m_ptr     = 0;
   int            m_last_g  = 0;
   int            m_cnt     = 0;
   logic [N-1:0]  prev_ack  = '0;
   logic          prev_out_req = 1'b0;
   logic [PKT_W-1:0] prev_out_data = '0;
   int            req_run      = 0;
   int            last_req_run = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
   endtask

   // Reference arbitration: first requester scanning forward from the pointer
   function automatic int m_pick(input logic [N-1:0] r, input int p);
      for (int k = 0; k < N; k++) begin
         if (r[(p + k) % N]) return (p + k) % N;
      end
      return -1;
   endfunction

   function automatic pkt_t mk_pkt(input int dst, input int src);
      pkt_t p;
      p = '0;
      p[DST_MSB:DST_LSB] = 4'(dst);
      p[SRC_MSB:SRC_LSB] = 4'(src);
      p[TYP_MSB:TYP_LSB] = 2'($urandom);
      p[PAY_MSB:PAY_LSB] = 25'($urandom);
      return p;
   endfunction

   // Invariant checks, scoreboard and the source/NoC partners; runs once per negedge
   task automatic agents();
      int g;
      chk("ack_onehot0", 64'($onehot0(in_ack)), 64'(1));
      if (out_req) begin
         chk("ack_low_in_send", 64'(in_ack), 64'(0));
         chk("busy_in_send", 64'(busy), 64'(1));
      end
      if (in_ack != '0) chk("ack_matches_grant", 64'(in_ack[grant_idx]), 64'(1));
      if (out_req && prev_out_req) chk("out_data_stable", 64'(out_data), 64'(prev_out_data));

      for (int i = 0; i < N; i++) begin
         if (in_ack[i] && !prev_ack[i]) begin
            g = m_pick(in_req, m_ptr);
            chk("grant_port", 64'(i), 64'(g));
            chk("grant_idx", 64'(grant_idx), 64'(g));
            got_order.push_back(i);
            if (src_q[i].size() > 0) exp_q.push_back(src_q[i][0]);
            m_last_g = i;
         end
      end

      if (out_req) req_run++;
      else if (prev_out_req) begin
         last_req_run = req_run;
         req_run      = 0;
      end

      if (out_req && !out_ack) begin
         if (noc_cnt >= noc_delay) begin
            if (exp_q.size() == 0) chk("unexpected_packet", 64'(1), 64'(0));
            else chk("out_data", 64'(out_data), 64'(exp_q.pop_front()));
            out_ack = 1'b1;
            noc_cnt = 0;
            if (noc_rand) noc_delay = $urandom_range(0, 3);
         end else begin
            noc_cnt++;
         end
      end else if (!out_req && out_ack) begin
         out_ack = 1'b0;
         m_cnt++;
         m_ptr = (m_last_g + 1) % N;
      end

      for (int i = 0; i < N; i++) begin
         if (in_req[i] && in_ack[i]) begin
            if (src_wait[i] > 0) src_wait[i]--;
            else begin
               in_req[i] = 1'b0;
               void'(src_q[i].pop_front());
               src_wait[i] = $urandom_range(0, src_wait_max);
            end
         end else if (!in_req[i] && !in_ack[i] && src_q[i].size() > 0) begin
            in_req[i] = 1'b1;
            in_data[i*PKT_W +: PKT_W] = src_q[i][0];
         end
      end

      prev_ack      = in_ack;
      prev_out_req  = out_req;
      prev_out_data = out_data;
   endtask

   task automatic step();
      @(negedge clk);
      agents();
   endtask

   function automatic bit pending();
      bit p;
      p = busy || out_req || out_ack || (in_req != '0);
      for (int i = 0; i < N; i++) if (src_q[i].size() > 0) p = 1'b1;
      return p;
   endfunction

   task automatic drain(input string tag);
      int t;
      t = 0;
      do begin
         step();
         t++;
      end while (pending() && t < 3000);
      if (t >= 3000) chk({tag, "_timeout"}, 64'(1), 64'(0));
      chk({tag, "_pkt_count"}, 64'(pkt_count), 64'(m_cnt % (1 << CW)));
      chk({tag, "_busy_idle"}, 64'(busy), 64'(0));
   endtask

   task automatic tb_reset();
      rst_n   = 1'b0;
      in_req  = '0;
      out_ack = 1'b0;
      for (int i = 0; i < N; i++) begin
         src_q[i].delete();
         src_wait[i] = 0;
      end
      exp_q.delete();
      got_order.delete();
      m_ptr        = 0;
      m_cnt        = 0;
      m_last_g     = 0;
      noc_cnt      = 0;
      prev_ack     = '0;
      prev_out_req = 1'b0;
      prev_out_data = '0;
      req_run      = 0;
   endtask

   initial begin
      int n;
      int ones;
      in_data = '0;
      tb_reset();
      #1;
      chk("rst_in_ack", 64'(in_ack), 64'(0));
      chk("rst_out_req", 64'(out_req), 64'(0));
      chk("rst_out_data", 64'(out_data), 64'(0));
      chk("rst_grant_idx", 64'(grant_idx), 64'(0));
      chk("rst_busy", 64'(busy), 64'(0));
      chk("rst_pkt_count", 64'(pkt_count), 64'(0));
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      // single packet from port 0 with zero-latency partners
      src_q[0].push_back(35'h0000_0000F);
      step();
      n = 0;
      while (pkt_count != 1 && n < 20) begin
         step();
         n++;
      end
      chk("t1_latency", 64'(n), 64'(4));
      chk("t1_out_data", 64'(out_data), 64'h0000_0000F);
      chk("t1_grant_idx", 64'(grant_idx), 64'(0));
      chk("t1_pkt_count", 64'(pkt_count), 64'(1));
      drain("t1");
      // pointer now past port 0: simultaneous 0 and 1 -> 1 first
      got_order.delete();
      src_q[0].push_back(mk_pkt(0, 0));
      src_q[1].push_back(mk_pkt(0, 1));
      drain("t1b");
      chk("t1b_first", 64'(got_order[0]), 64'(1));
      chk("t1b_second", 64'(got_order[1]), 64'(0));

      // all four request at once after reset
      tb_reset();
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < N; i++) src_q[i].push_back(mk_pkt(5, i));
      drain("t2");
      chk("t2_n_grants", 64'(got_order.size()), 64'(4));
      for (int i = 0; i < 4; i++) chk("t2_order", 64'(got_order[i]), 64'(i));

      // pointer wrapped to 0: ports 3 and 0 request
      got_order.delete();
      src_q[3].push_back(mk_pkt(1, 3));
      src_q[0].push_back(mk_pkt(1, 0));
      drain("t3");
      chk("t3_first", 64'(got_order[0]), 64'(0));
      chk("t3_second", 64'(got_order[1]), 64'(3));

      // NoC stalls acknowledge for 10 cycles
      noc_delay = 10;
      src_q[2].push_back(mk_pkt(7, 2));
      drain("t4");
      chk("t4_req_hold", 64'(last_req_run), 64'(11));
      noc_delay = 0;

      // reset asserted while a packet sits in SEND
      noc_delay = 20;
      src_q[1].push_back(mk_pkt(3, 1));
      n = 0;
      while (!out_req && n < 20) begin
         step();
         n++;
      end
      chk("t5_reached_send", 64'(out_req), 64'(1));
      repeat (3) step();
      #2;
      rst_n = 1'b0;
      #1;
      chk("t5_out_req", 64'(out_req), 64'(0));
      chk("t5_in_ack", 64'(in_ack), 64'(0));
      chk("t5_pkt_count", 64'(pkt_count), 64'(0));
      chk("t5_busy", 64'(busy), 64'(0));
      tb_reset();
      noc_delay = 0;
      @(negedge clk);
      rst_n = 1'b1;
      src_q[3].push_back(mk_pkt(2, 3));
      src_q[2].push_back(mk_pkt(2, 2));
      src_q[0].push_back(mk_pkt(2, 0));
      drain("t5b");
      chk("t5b_first", 64'(got_order[0]), 64'(0));
      chk("t5b_second", 64'(got_order[1]), 64'(2));
      chk("t5b_third", 64'(got_order[2]), 64'(3));

      // counter wrap with a 4-bit counter, all from port 1
      tb_reset();
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 15; k++) src_q[1].push_back(mk_pkt(k, 1));
      drain("t6a");
      chk("t6a_count15", 64'(pkt_count), 64'(15));
      src_q[1].push_back(mk_pkt(9, 1));
      drain("t6b");
      chk("t6b_wrap", 64'(pkt_count), 64'(0));
      ones = 0;
      foreach (got_order[k]) if (got_order[k] == 1) ones++;
      chk("t6_all_port1", 64'(ones), 64'(16));
      chk("t6_n_grants", 64'(got_order.size()), 64'(16));

      // randomized traffic with random partner latencies
      src_wait_max = 2;
      noc_rand     = 1'b1;
      for (int r = 0; r < 25; r++) begin
         for (int i = 0; i < N; i++) begin
            if ($urandom_range(0, 1) == 1) src_q[i].push_back(mk_pkt(r % 16, i));
         end
         repeat ($urandom_range(0, 8)) step();
      end
      drain("rand");
      chk("rand_scoreboard_empty", 64'(exp_q.size()), 64'(0));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
